// File: rtl/fir_pkg.sv
// Shared constants and state type for the split-FIR result collector.
package fir_pkg;

  localparam int unsigned ACC_W   = 16;
  localparam int unsigned OUT_W   = 16;
  localparam int unsigned NUM_MOD = 4;

  typedef enum logic [1:0] {
    COLLECT,
    ADD,
    HOLD
  } state_e;

endpackage

// File: rtl/fir_sat.sv
// Combinational signed saturation from IN_W bits down to OUT_W bits (IN_W >= OUT_W).
module fir_sat #(
  parameter int unsigned IN_W  = 18,
  parameter int unsigned OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  i_val,
  output logic signed [OUT_W-1:0] o_val
);

  localparam logic signed [IN_W-1:0] MaxV = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] MinV = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  always_comb begin
    if (i_val > MaxV) begin
      o_val = MaxV[OUT_W-1:0];
    end else if (i_val < MinV) begin
      o_val = MinV[OUT_W-1:0];
    end else begin
      o_val = i_val[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/fir_result_collector.sv
// Captures the four MAC partial sums, adds them in two stages, saturates and
// presents the sample on a valid/ready port.
module fir_result_collector
  import fir_pkg::*;
(
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iClr,
  input  logic             iMacValid1,
  input  logic             iMacValid2,
  input  logic             iMacValid3,
  input  logic             iMacValid4,
  input  logic [ACC_W-1:0] iMac1,
  input  logic [ACC_W-1:0] iMac2,
  input  logic [ACC_W-1:0] iMac3,
  input  logic [ACC_W-1:0] iMac4,
  input  logic             iFirReady,
  output logic             oFirValid,
  output logic [OUT_W-1:0] oFirOut,
  output logic             oBusy,
  output logic             oOverrun
);

  localparam int unsigned S_W = ACC_W + 1;
  localparam int unsigned T_W = ACC_W + 2;

  state_e                    r_state;
  state_e                    w_state_d;
  logic [NUM_MOD-1:0]        r_mask;
  logic [NUM_MOD-1:0]        w_mask_d;
  logic signed [ACC_W-1:0]   r_cap [NUM_MOD];
  logic signed [S_W-1:0]     r_s01;
  logic signed [S_W-1:0]     r_s23;
  logic [OUT_W-1:0]          r_out;
  logic                      r_valid;
  logic                      r_overrun;

  logic [NUM_MOD-1:0]        w_valid;
  logic signed [ACC_W-1:0]   w_mac [NUM_MOD];
  logic [NUM_MOD-1:0]        w_cap_en;
  logic [NUM_MOD-1:0]        w_dup;
  logic                      w_xfer;
  logic                      w_load;
  logic signed [T_W-1:0]     w_total;
  logic signed [OUT_W-1:0]   w_sat;

  always_comb begin
    w_valid  = {iMacValid4, iMacValid3, iMacValid2, iMacValid1};
    w_mac[0] = iMac1;
    w_mac[1] = iMac2;
    w_mac[2] = iMac3;
    w_mac[3] = iMac4;
  end

  // iClr suppresses both capture and duplicate reporting in its cycle.
  always_comb begin
    w_cap_en = w_valid & ~r_mask & {NUM_MOD{~iClr}};
    w_dup    = w_valid & r_mask & {NUM_MOD{~iClr}};
  end

  always_comb begin
    w_state_d = r_state;
    w_xfer    = 1'b0;
    w_load    = 1'b0;
    unique case (r_state)
      COLLECT: begin
        if ((&r_mask) && !iClr) begin
          w_xfer    = 1'b1;
          w_state_d = ADD;
        end
      end
      ADD: begin
        w_load    = 1'b1;
        w_state_d = HOLD;
      end
      HOLD: begin
        if (iFirReady) begin
          w_state_d = COLLECT;
        end
      end
      default: w_state_d = COLLECT;
    endcase
  end

  always_comb begin
    if (iClr || w_xfer) begin
      w_mask_d = '0;
    end else begin
      w_mask_d = r_mask | w_cap_en;
    end
  end

  always_comb begin
    w_total = {r_s01[S_W-1], r_s01} + {r_s23[S_W-1], r_s23};
  end

  fir_sat #(
    .IN_W  (T_W),
    .OUT_W (OUT_W)
  ) u_sat (
    .i_val (w_total),
    .o_val (w_sat)
  );

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state <= COLLECT;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_mask    <= '0;
      r_s01     <= '0;
      r_s23     <= '0;
      r_out     <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
      for (int n = 0; n < NUM_MOD; n++) begin
        r_cap[n] <= '0;
      end
    end else begin
      r_mask    <= w_mask_d;
      r_overrun <= |w_dup;
      for (int n = 0; n < NUM_MOD; n++) begin
        if (iClr) begin
          r_cap[n] <= '0;
        end else if (w_cap_en[n]) begin
          r_cap[n] <= w_mac[n];
        end
      end
      if (w_xfer) begin
        r_s01 <= {r_cap[0][ACC_W-1], r_cap[0]} + {r_cap[1][ACC_W-1], r_cap[1]};
        r_s23 <= {r_cap[2][ACC_W-1], r_cap[2]} + {r_cap[3][ACC_W-1], r_cap[3]};
      end
      if (w_load) begin
        r_out   <= w_sat;
        r_valid <= 1'b1;
      end else if ((r_state == HOLD) && iFirReady) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign oFirValid = r_valid;
  assign oFirOut   = r_out;
  assign oBusy     = (r_state != COLLECT);
  assign oOverrun  = r_overrun;

endmodule

// File: doc/fir_result_collector.md
# fir_result_collector

Gathers the four per-sub-module MAC partial sums of the 4-way split FIR filter and reduces them to one filter output sample. Sits at the output end of the sub-module array, opposite the control demultiplexer that fans SRAM/MAC controls out to sub-modules 1..4. Captures each partial as its MAC reports completion, sums the four in a two-stage pipeline, saturates, and presents the result on a valid/ready port.

## Interface
- ACC_W, 16: width of each signed MAC partial sum.
- OUT_W, 16: width of the signed saturated output; OUT_W <= ACC_W + 2.
- iClk  in  1  system clock, rising edge.
- iRst  in  1  synchronous reset, active-high (one clock, synchronous, active-high: fixed).
- iClr  in  1  synchronous abort; discards captured partials.
- iMacValid1..iMacValid4  in  1 each  one-cycle pulse: partial of sub-module N is valid this cycle.
- iMac1..iMac4  in  ACC_W each  signed partial sums.
- iFirReady  in  1  downstream accepts oFirOut.
- oFirValid  out  1  oFirOut holds a result.
- oFirOut  out  OUT_W  signed saturated sum.
- oBusy  out  1  high in ADD or HOLD.
- oOverrun  out  1  one-cycle pulse: duplicate iMacValidN while bit N already captured.

## Operation
- Reset: state COLLECT, capture mask 4'b0000, capture registers 0, oFirValid 0, oFirOut 0, oBusy 0, oOverrun 0.
- Capture, any state: iMacValidN high and mask[N] clear -> store iMacN, set mask[N]. Multiple N in one cycle are captured together.
- Duplicate: iMacValidN high and mask[N] set -> first value kept, new value dropped, oOverrun pulses next cycle (one pulse even if several duplicates coincide).
- COLLECT: mask == 4'hF -> register s01 = iMac1+iMac2 and s23 = iMac3+iMac4 (ACC_W+1 bits, sign-extended), clear mask, go ADD.
- ADD: total = s01 + s23 (ACC_W+2 bits); saturate to OUT_W (> max -> 2^(OUT_W-1)-1; < min -> -2^(OUT_W-1)); load oFirOut, set oFirValid, go HOLD.
- HOLD: oFirValid high, oFirOut stable until iFirReady sampled high; then oFirValid 0 and state COLLECT. Captures for the next frame continue during ADD/HOLD; a mask that fills during HOLD waits in COLLECT.
- iClr: clears mask and capture registers next edge; does not disturb ADD/HOLD (an in-flight result completes). iClr and iMacValidN in the same cycle: iClr wins, nothing captured.
- iRst has priority over everything, including mid-HOLD (result lost, oFirValid 0 next cycle).

## Timing
- Last missing iMacValidN sampled at edge k -> mask full after k; s01/s23 loaded at k+1; oFirValid high after edge k+2 (3-cycle latency from the pulse cycle).
- iFirReady high while oFirValid high at edge m -> oFirValid low after m; earliest next oFirValid after m+2 if the mask was already full (one COLLECT bubble).
- iFirReady ignored while oFirValid low.
- oOverrun asserted exactly one cycle, the cycle after the duplicate pulse.

## Structure
- Shared package fir_pkg: ACC_W, OUT_W, NUM_MOD = 4, state enum {COLLECT, ADD, HOLD}.
- One sub-module: fir_sat (combinational, parameterised IN_W/OUT_W signed saturation), reusable by the MAC.
- Capture registers and mask as 4-element arrays indexed by module.

## Test plan
- Pulses 1..4 in separate cycles with 100, 200, -50, 25 -> oFirOut = 275, oFirValid high 3 cycles after pulse 4; iFirReady held 1 -> one-cycle valid.
- All four pulses same cycle, each 16'h7000 -> oFirOut = 16'h7FFF (saturated); each 16'h9000 -> 16'h8000.
- Valid result with iFirReady 0 for 5 cycles while a full second frame (1,1,1,1) arrives -> first result stable all 5 cycles; after accept, 4 appears 2 cycles later.
- iMacValid2 pulsed twice (10 then 99) before completing with 1, 3, 4 at 0 -> oOverrun pulses once, oFirOut = 10.
- Three partials captured, then iClr, then full new frame 5,5,5,5 -> oFirOut = 20; iClr in same cycle as iMacValid4 -> no capture.
- iRst asserted in HOLD -> next cycle oFirValid 0, oFirOut 0, oBusy 0, mask empty.
